// File: rtl/divisor_salida.sv
// Output stage of the pipelined restoring divider: sign correction plus a show-ahead result FIFO.
// Optional divide-by-zero handling is enabled by defining DIVISOR_DIVZERO_EN.
module divisor_salida #(
  parameter int tamanyo = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  input  logic                       Done_in,
  input  logic [tamanyo-1:0]         ACCU_in,
  input  logic [tamanyo-1:0]         Q_in,
  input  logic [tamanyo-1:0]         M_in,
  input  logic                       SignNum_in,
  input  logic                       SignDen_in,
  input  logic                       Ready,
  output logic [tamanyo-1:0]         Coc,
  output logic [tamanyo-1:0]         Res,
  output logic                       DivZero,
  output logic                       Valid,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 2 * tamanyo + 1;

  // Two's-complement negation wraps modulo 2^tamanyo, so MIN stays MIN.
  function automatic logic signed [tamanyo-1:0] neg_if(input logic [tamanyo-1:0] mag,
                                                       input logic            neg);
    logic signed [tamanyo-1:0] m;
    m = signed'(mag);
    return neg ? -m : m;
  endfunction

  logic signed [tamanyo-1:0] coc_new;
  logic signed [tamanyo-1:0] res_new;
  logic                      dz_new;
  logic [EW-1:0]             entry;

  logic [EW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           full, pop, push_ok;
  logic [EW-1:0]  head;

`ifndef DIVISOR_DIVZERO_EN
  logic unused_m;
  assign unused_m = |M_in;
`endif

  // Stage p0: combinational sign correction of the incoming result
  always_comb begin
    coc_new = neg_if(Q_in, SignNum_in ^ SignDen_in);
    res_new = neg_if(ACCU_in, SignNum_in);
    dz_new  = 1'b0;
`ifdef DIVISOR_DIVZERO_EN
    if (M_in == '0) begin
      dz_new  = 1'b1;
      coc_new = SignNum_in ? {1'b1, {(tamanyo-1){1'b0}}} : {1'b0, {(tamanyo-1){1'b1}}};
      res_new = '0;
    end
`endif
    entry = {dz_new, coc_new, res_new};
  end

  always_comb begin
    full       = (count_q == (PW+1)'(DEPTH));
    pop        = (count_q != '0) && Ready;
    push_ok    = Done_in && (!full || pop);
    overflow_d = overflow_q | (Done_in && full && !pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Stage p1: FIFO storage (data only, no reset)
  always_ff @(posedge CLK) begin
    if (push_ok && RSTa) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  // Empty FIFO presents zeros, which also covers the reset state of the outputs.
  assign head     = mem_q[rd_ptr_q];
  assign Valid    = (count_q != '0);
  assign Coc      = Valid ? head[EW-2 -: tamanyo] : '0;
  assign Res      = Valid ? head[tamanyo-1:0] : '0;
  assign DivZero  = Valid ? head[EW-1] : 1'b0;
  assign Count    = count_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_divisor_salida.sv
// Directed-vector bench for divisor_salida (tamanyo=32, DEPTH=4).
module tb_divisor_salida;

  logic        CLK = 1'b0;
  logic        RSTa;
  logic        Done_in;
  logic [31:0] ACCU_in, Q_in, M_in;
  logic        SignNum_in, SignDen_in, Ready;
  logic [31:0] Coc, Res;
  logic        DivZero, Valid, Overflow;
  logic [2:0]  Count;

  int n_vec = 0;
  int n_bad = 0;

  divisor_salida #(.tamanyo(32), .DEPTH(4)) dut (
    .CLK(CLK), .RSTa(RSTa), .Done_in(Done_in), .ACCU_in(ACCU_in), .Q_in(Q_in),
    .M_in(M_in), .SignNum_in(SignNum_in), .SignDen_in(SignDen_in), .Ready(Ready),
    .Coc(Coc), .Res(Res), .DivZero(DivZero), .Valid(Valid), .Count(Count),
    .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] q, input logic [31:0] r, input logic sn, input logic sd);
    Q_in = q; ACCU_in = r; SignNum_in = sn; SignDen_in = sd; M_in = 32'd2;
    Done_in = 1'b1;
    tick();
    Done_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_coc"}, Coc, 0);
    check({tag, "_res"}, Res, 0);
    check({tag, "_dz"}, DivZero, 0);
    check({tag, "_valid"}, Valid, 0);
    check({tag, "_count"}, Count, 0);
    check({tag, "_ovf"}, Overflow, 0);
  endtask

  initial begin
    RSTa = 1'b0; Done_in = 1'b0; ACCU_in = '0; Q_in = '0; M_in = 32'd2;
    SignNum_in = 1'b0; SignDen_in = 1'b0; Ready = 1'b0;
    #2;
    check_zero("rst");
    tick();
    RSTa = 1'b1;

    // 7 / -2
    push(32'd3, 32'd1, 1'b0, 1'b1);
    check("p_n_valid", Valid, 1);
    check("p_n_coc", Coc, 32'hFFFF_FFFD);
    check("p_n_res", Res, 32'h0000_0001);
    check("p_n_count", Count, 1);
    Ready = 1'b1; tick(); Ready = 1'b0;
    check("pop_valid", Valid, 0);
    check("pop_count", Count, 0);

    // -7 / 2 and -7 / -2 queued back to back
    push(32'd3, 32'd1, 1'b1, 1'b0);
    push(32'd3, 32'd1, 1'b1, 1'b1);
    check("n_p_coc", Coc, 32'hFFFF_FFFD);
    check("n_p_res", Res, 32'hFFFF_FFFF);
    check("two_count", Count, 2);
    Ready = 1'b1; tick(); Ready = 1'b0;
    check("n_n_coc", Coc, 32'h0000_0003);
    check("n_n_res", Res, 32'hFFFF_FFFF);
    Ready = 1'b1; tick(); Ready = 1'b0;

    // MIN / -1 wraps to MIN
    push(32'h8000_0000, 32'd0, 1'b1, 1'b1);
    check("min_coc", Coc, 32'h8000_0000);
    check("min_res", Res, 32'h0000_0000);
    Ready = 1'b1; tick(); Ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) push(32'd20 + i, 32'd0, 1'b0, 1'b0);
    check("full_count", Count, 4);
    check("full_ovf", Overflow, 0);
    check("full_hold_coc", Coc, 32'd20);
    Q_in = 32'd24; Done_in = 1'b1; Ready = 1'b1;
    tick();
    Done_in = 1'b0;
    check("pp_count", Count, 4);
    check("pp_ovf", Overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_drain%0d", i), Coc, 32'd21 + i);
      tick();
    end
    check("pp_empty", Valid, 0);
    Ready = 1'b0;

    // Overflow: five pushes into a 4-deep FIFO
    for (int i = 0; i < 5; i++) push(32'd10 + i, 32'd0, 1'b0, 1'b0);
    check("ovf_count", Count, 4);
    check("ovf_flag", Overflow, 1);
    Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d", i), Coc, 32'd10 + i);
      tick();
    end
    check("ovf_empty", Valid, 0);
    check("ovf_sticky", Overflow, 1);
    Ready = 1'b0;

    // Division by zero entry (-5 / 0, remainder 2)
    Q_in = 32'd5; ACCU_in = 32'd2; SignNum_in = 1'b1; SignDen_in = 1'b0; M_in = 32'd0;
    Done_in = 1'b1;
    tick();
    Done_in = 1'b0; M_in = 32'd2;
`ifdef DIVISOR_DIVZERO_EN
    check("dz_flag", DivZero, 1);
    check("dz_coc", Coc, 32'h8000_0000);
    check("dz_res", Res, 32'h0000_0000);
`else
    check("dz_flag", DivZero, 0);
    check("dz_coc", Coc, 32'hFFFF_FFFB);
    check("dz_res", Res, 32'hFFFF_FFFE);
`endif

    // Asynchronous reset mid-cycle with Count=3, Overflow=1
    push(32'd7, 32'd0, 1'b0, 1'b0);
    push(32'd8, 32'd0, 1'b0, 1'b0);
    check("pre_rst_count", Count, 3);
    check("pre_rst_ovf", Overflow, 1);
    #2;
    Done_in = 1'b1; RSTa = 1'b0;
    #1;
    check_zero("arst");
    tick();
    RSTa = 1'b1; Done_in = 1'b0;
    tick();
    check("post_rst_valid", Valid, 0);
    check("post_rst_count", Count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
